hiscore_ram_arbiter: RTL and testbench

HISCORE_RAM_ARBITER -- requirements
Module: hiscore_ram_arbiter

---
 rtl/hiscore_ram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_hiscore_ram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_ram_arbiter.sv
// Shares the CPU work-RAM port with the hiscore engine: pauses the CPU, lets the
// bus settle, grants the port, then parks it briefly before handing it back.
module hiscore_ram_arbiter #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int RELEASE_CYCLES = 2,
    parameter int ACK_TIMEOUT    = 1023
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    output logic [7:0]  cpu_dout,
    input  logic        hs_intent_read,
    input  logic        hs_intent_write,
    input  logic [15:0] hs_address,
    input  logic [7:0]  hs_data_in,
    input  logic        hs_write,
    output logic [7:0]  hs_data_out,
    output logic        hs_grant,
    output logic        pause_req,
    input  logic        pause_ack,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout,
    output logic        timeout_err
);

    localparam int WAIT_W   = (ACK_TIMEOUT    > 0) ? $clog2(ACK_TIMEOUT + 1)    : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES  > 0) ? $clog2(SETTLE_CYCLES + 1)  : 1;
    localparam int REL_W    = (RELEASE_CYCLES > 0) ? $clog2(RELEASE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_PAUSE,
        ST_SETTLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [REL_W-1:0]    r_rel_cnt;
    logic                r_timeout_err;
    logic [7:0]          r_cpu_dout;
    logic [15:0]         r_addr_hold;

    logic w_intent;
    logic w_wait_done;
    logic w_settle_done;
    logic w_rel_done;
    logic w_timeout_hit;
    logic w_cpu_side;
    logic w_grant;

    assign w_intent      = hs_intent_read | hs_intent_write;
    // Each "done" fires on the last cycle of its phase, so a phase lasts exactly N cycles.
    assign w_wait_done   = (int'(r_wait_cnt)   + 1 >= ACK_TIMEOUT);
    assign w_settle_done = (int'(r_settle_cnt) + 1 >= SETTLE_CYCLES);
    assign w_rel_done    = (int'(r_rel_cnt)    + 1 >= RELEASE_CYCLES);

    // State register and all sequential state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk_sys) begin
        // NOTE: reset is synchronous, so it only acts on a clock edge.
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_settle_cnt  <= '0;
            r_rel_cnt     <= '0;
            r_timeout_err <= 1'b0;
            r_cpu_dout    <= 8'h00;
            r_addr_hold   <= 16'h0000;
        end else begin
            r_state <= w_next;

            if (r_state == ST_REQ_PAUSE && w_next == ST_REQ_PAUSE) begin
                if (r_wait_cnt != WAIT_W'(ACK_TIMEOUT))
                    r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            if (r_state == ST_SETTLE && w_next == ST_SETTLE) begin
                if (r_settle_cnt != SETTLE_W'(SETTLE_CYCLES))
                    r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end

            if (r_state == ST_RELEASE && w_next == ST_RELEASE) begin
                if (r_rel_cnt != REL_W'(RELEASE_CYCLES))
                    r_rel_cnt <= r_rel_cnt + 1'b1;
            end else begin
                r_rel_cnt <= '0;
            end

            if (w_timeout_hit)
                r_timeout_err <= 1'b1;

            if (w_cpu_side) begin
                r_cpu_dout  <= ram_dout;
                r_addr_hold <= cpu_addr;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_intent)
                    w_next = ST_REQ_PAUSE;
            end
            ST_REQ_PAUSE: begin
                if (pause_ack) begin
                    w_next = (SETTLE_CYCLES == 0) ? ST_GRANT : ST_SETTLE;
                end else if (!w_intent) begin
                    w_next = ST_RELEASE;
                end else if (w_wait_done) begin
                    w_next        = ST_RELEASE;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!w_intent)
                    w_next = ST_RELEASE;
                else if (w_settle_done)
                    w_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (!w_intent)
                    w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (w_rel_done)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Output logic: port mux decoded straight from the registered state.
    always_comb begin
        w_cpu_side = 1'b0;
        w_grant    = 1'b0;
        ram_addr   = cpu_addr;
        ram_din    = cpu_din;
        ram_we     = cpu_cs & cpu_we;
        case (r_state)
            ST_IDLE, ST_REQ_PAUSE: begin
                w_cpu_side = 1'b1;
            end
            ST_GRANT: begin
                w_grant  = 1'b1;
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                ram_we   = hs_write;
            end
            default: begin
                ram_addr = r_addr_hold;
                ram_we   = 1'b0;
            end
        endcase
    end

    assign pause_req   = (r_state != ST_IDLE);
    assign hs_grant    = w_grant;
    assign hs_data_out = w_grant ? ram_dout : 8'h00;
    assign cpu_dout    = r_cpu_dout;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter at default parameters; cycle numbers in
// each scenario count edges from the cycle the first intent is raised.
module tb_hiscore_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_cs;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic        hs_intent_read;
    logic        hs_intent_write;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic        hs_write;
    logic [7:0]  hs_data_out;
    logic        hs_grant;
    logic        pause_req;
    logic        pause_ack;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    hiscore_ram_arbiter dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .cpu_addr        (cpu_addr),
        .cpu_din         (cpu_din),
        .cpu_cs          (cpu_cs),
        .cpu_we          (cpu_we),
        .cpu_dout        (cpu_dout),
        .hs_intent_read  (hs_intent_read),
        .hs_intent_write (hs_intent_write),
        .hs_address      (hs_address),
        .hs_data_in      (hs_data_in),
        .hs_write        (hs_write),
        .hs_data_out     (hs_data_out),
        .hs_grant        (hs_grant),
        .pause_req       (pause_req),
        .pause_ack       (pause_ack),
        .ram_addr        (ram_addr),
        .ram_din         (ram_din),
        .ram_we          (ram_we),
        .ram_dout        (ram_dout),
        .timeout_err     (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lands 1ns after the rising edge; inputs are driven next, outputs checked 1ns later.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    logic exp_grant;
    logic exp_pause;
    logic seen_grant;

    initial begin
        reset = 1'b1; cpu_addr = 16'h0000; cpu_din = 8'h00; cpu_cs = 1'b0; cpu_we = 1'b0;
        hs_intent_read = 1'b0; hs_intent_write = 1'b0; hs_address = 16'h0000;
        hs_data_in = 8'h00; hs_write = 1'b0; pause_ack = 1'b0; ram_dout = 8'hFF;

        // Reset state: cpu_dout must be 0 even though ram_dout is FF.
        tick(); tick(); #1;
        check("rst_pause_req", pause_req, 1'b0);
        check("rst_hs_grant", hs_grant, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_cpu_dout", cpu_dout, 8'h00);

        // IDLE passthrough of a CPU write.
        reset = 1'b0; ram_dout = 8'hC3; cpu_addr = 16'h1234; cpu_din = 8'hA5;
        cpu_cs = 1'b1; cpu_we = 1'b1; hs_write = 1'b1;
        #1;
        check("idle_ram_addr", ram_addr, 16'h1234);
        check("idle_ram_din", ram_din, 8'hA5);
        check("idle_ram_we", ram_we, 1'b1);
        cpu_we = 1'b0;
        #1;
        check("idle_hs_write_ignored", ram_we, 1'b0);
        cpu_cs = 1'b0; hs_write = 1'b0;

        // Cycle 0 of the handshake; cpu_dout has captured C3 from IDLE.
        tick();
        hs_intent_write = 1'b1;
        #1;
        check("cpu_dout_load", cpu_dout, 8'hC3);
        check("hs0_pause_req", pause_req, 1'b0);

        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            if (cyc == 3) pause_ack = 1'b1;
            if (cyc == 4) begin
                ram_dout = 8'h99; cpu_addr = 16'hBEEF; cpu_din = 8'h77; cpu_cs = 1'b1; cpu_we = 1'b1;
                hs_write = 1'b1; hs_address = 16'h8A20; hs_data_in = 8'h5C;
            end
            if (cyc == 9)  pause_ack = 1'b0;
            if (cyc == 11) hs_intent_write = 1'b0;
            if (cyc == 12) begin hs_write = 1'b0; hs_intent_read = 1'b1; end
            if (cyc == 14) hs_intent_read = 1'b0;
            #1;
            exp_grant = (cyc >= 8 && cyc <= 11);
            exp_pause = (cyc <= 13);
            check($sformatf("hs_grant_c%0d", cyc), hs_grant, exp_grant);
            check($sformatf("pause_req_c%0d", cyc), pause_req, exp_pause);
            if ((cyc >= 4 && cyc <= 7) || cyc == 12 || cyc == 13) begin
                check($sformatf("parked_we_c%0d", cyc), ram_we, 1'b0);
                check($sformatf("parked_addr_c%0d", cyc), ram_addr, 16'h1234);
                check($sformatf("parked_hs_dout_c%0d", cyc), hs_data_out, 8'h00);
            end
            if (exp_grant) begin
                check($sformatf("grant_addr_c%0d", cyc), ram_addr, 16'h8A20);
                check($sformatf("grant_din_c%0d", cyc), ram_din, 8'h5C);
                check($sformatf("grant_we_c%0d", cyc), ram_we, 1'b1);
                check($sformatf("grant_hs_dout_c%0d", cyc), hs_data_out, 8'h99);
                check($sformatf("grant_cpu_dout_c%0d", cyc), cpu_dout, 8'hC3);
            end
            if (cyc == 14) begin
                check("back_idle_we", ram_we, 1'b1);
                check("back_idle_addr", ram_addr, 16'hBEEF);
                check("back_idle_cpu_dout", cpu_dout, 8'hC3);
            end
        end
        cpu_cs = 1'b0; cpu_we = 1'b0;

        // Intents drop in SETTLE's second cycle: RELEASE at 4,5, IDLE at 6, never granted.
        tick();
        hs_intent_read = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            if (cyc == 1) pause_ack = 1'b1;
            if (cyc == 3) begin hs_intent_read = 1'b0; pause_ack = 1'b0; end
            #1;
            check($sformatf("sd_hs_grant_c%0d", cyc), hs_grant, 1'b0);
            check($sformatf("sd_pause_req_c%0d", cyc), pause_req, (cyc <= 5));
        end

        // Timeout: REQ_PAUSE spans cycles 1..1023, RELEASE 1024-1025, IDLE 1026.
        tick();
        hs_intent_write = 1'b1;
        seen_grant = 1'b0;
        for (int cyc = 1; cyc <= 1026; cyc++) begin
            tick();
            if (cyc == 1024) hs_intent_write = 1'b0;
            #1;
            seen_grant = seen_grant | hs_grant;
            if (cyc == 1023) begin
                check("to_err_before", timeout_err, 1'b0);
                check("to_pause_1023", pause_req, 1'b1);
            end
            if (cyc == 1024) begin
                check("to_err_set", timeout_err, 1'b1);
                check("to_pause_1024", pause_req, 1'b1);
            end
            if (cyc == 1025) check("to_pause_1025", pause_req, 1'b1);
            if (cyc == 1026) begin
                check("to_pause_idle", pause_req, 1'b0);
                check("to_err_sticky", timeout_err, 1'b1);
            end
        end
        check("to_never_granted", seen_grant, 1'b0);

        // Mid-GRANT reset: ack held from cycle 1 gives GRANT at cycle 6.
        tick();
        hs_intent_write = 1'b1; pause_ack = 1'b1;
        hs_address = 16'h0F0F; hs_data_in = 8'h3E; hs_write = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) tick();
        #1;
        check("mr_granted", hs_grant, 1'b1);
        check("mr_err_still_set", timeout_err, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0; hs_intent_write = 1'b0; pause_ack = 1'b0;
        cpu_addr = 16'h4321; cpu_cs = 1'b1; cpu_we = 1'b0;
        #1;
        check("mr_hs_grant", hs_grant, 1'b0);
        check("mr_pause_req", pause_req, 1'b0);
        check("mr_ram_we_off", ram_we, 1'b0);
        check("mr_ram_addr", ram_addr, 16'h4321);
        check("mr_err_cleared", timeout_err, 1'b0);
        cpu_we = 1'b1;
        #1;
        check("mr_ram_we_cpu", ram_we, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
